// File: rtl/shared_mem_copy_master_pkg.sv
// Shared definitions for the shared-memory copy master: FSM encoding and
// bus word geometry.
package shared_mem_copy_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte stride between consecutive 32-bit words on the Avalon-MM port.
    localparam int BYTES_PER_WORD = 4;

    // Every transfer is a full 32-bit word.
    localparam logic [3:0] FULL_BYTEENABLE = 4'b1111;

endpackage

// File: rtl/shared_mem_copy_master_copy_fifo.sv
// Small synchronous FIFO buffering read data between the read and write
// halves of the copy engine. Head word is visible combinationally on pop_data.
module copy_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Qualify requests so a misbehaving caller cannot corrupt the pointers.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        full     = (count == CNT_W'(DEPTH));
        empty    = (count == '0);
        pop_data = mem[rd_ptr];
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/shared_mem_copy_master.sv
// Avalon-MM copy master: copies cmd_len 32-bit words from cmd_src to cmd_dst
// in shared memory using pipelined reads buffered through copy_fifo.
//
// Handshakes: the command is taken on any clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE. On the bus a read
// or write completes in any cycle its strobe is high and avm_waitrequest is
// low; until then address, strobes and writedata are held unchanged.
module shared_mem_copy_master
    import shared_mem_copy_master_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output state_t            dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_WORD - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  reads_issued;
    logic [LEN_W-1:0]  reads_issued_n;
    logic [LEN_W-1:0]  writes_done;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W:0]    occupancy;
    logic              cmd_fire;
    logic              rd_acc;
    logic              wr_acc;
    logic              bus_free;
    logic              issue_rd;
    logic              issue_wr;
    logic              last_wr;
    logic              fifo_push;
    logic [31:0]       fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    copy_fifo #(
        .DATA_W (32),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (avm_readdata),
        .pop       (issue_wr),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Request arbitration: decide the next bus request whenever the current
    // one (if any) completes this cycle; writes drain the buffer first.
    always_comb begin
        cmd_fire       = cmd_valid & cmd_ready;
        rd_acc         = avm_read & ~avm_waitrequest;
        wr_acc         = avm_write & ~avm_waitrequest;
        bus_free       = ~(avm_read | avm_write) | rd_acc | wr_acc;
        rd_addr_n      = rd_acc ? rd_addr + ADDR_STEP : rd_addr;
        wr_addr_n      = wr_acc ? wr_addr + ADDR_STEP : wr_addr;
        reads_issued_n = reads_issued + LEN_W'(rd_acc);
        // Buffer slots already committed, counting a read completing now.
        occupancy      = {1'b0, fifo_count} + {1'b0, outstanding} + (CNT_W + 1)'(rd_acc);
        issue_wr       = (state == ST_COPY) & bus_free & ~fifo_empty;
        issue_rd       = (state == ST_COPY) & bus_free & ~issue_wr
                       & (reads_issued_n < len_q)
                       & (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
        last_wr        = wr_acc & ((writes_done + LEN_W'(1)) == len_q);
        // Responses outside a copy are stale and dropped.
        fifo_push      = avm_readdatavalid & (state != ST_IDLE) & ~fifo_full;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_fire) state_nxt = (cmd_len == '0) ? ST_DONE : ST_COPY;
            ST_COPY: if (last_wr)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        cmd_ready      = (state == ST_IDLE);
        busy           = (state != ST_IDLE);
        done           = (state == ST_DONE);
        dbg_state      = state;
        avm_byteenable = FULL_BYTEENABLE;
    end

    // Copy datapath: address generators, counters and registered bus request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr       <= '0;
            wr_addr       <= '0;
            len_q         <= '0;
            reads_issued  <= '0;
            writes_done   <= '0;
            outstanding   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            rd_addr      <= rd_addr_n;
            wr_addr      <= wr_addr_n;
            reads_issued <= reads_issued_n;
            writes_done  <= writes_done + LEN_W'(wr_acc);
            outstanding  <= outstanding + CNT_W'(rd_acc) - CNT_W'(fifo_push);
            if (cmd_fire) begin
                // First read goes out straight from the handshake to save a cycle.
                rd_addr      <= cmd_src & ALIGN_MASK;
                wr_addr      <= cmd_dst & ALIGN_MASK;
                len_q        <= cmd_len;
                reads_issued <= '0;
                writes_done  <= '0;
                avm_read     <= (cmd_len != '0);
                avm_write    <= 1'b0;
                avm_address  <= cmd_src & ALIGN_MASK;
            end else if (bus_free) begin
                avm_read  <= issue_rd;
                avm_write <= issue_wr;
                if (issue_wr) begin
                    avm_address   <= wr_addr_n;
                    avm_writedata <= fifo_head;
                end else if (issue_rd) begin
                    avm_address <= rd_addr_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_shared_mem_copy_master.sv
// Directed bench for shared_mem_copy_master with a latency-1 memory model.
module tb_shared_mem_copy_master;
  import shared_mem_copy_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [17:0] cmd_src = '0;
  logic [17:0] cmd_dst = '0;
  logic [15:0] cmd_len = '0;
  logic        busy;
  logic        done;
  logic [17:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  state_t      dbg_state;

  int n_checks = 0;
  int n_pass = 0;

  logic [17:0] rd_log[$];
  logic [17:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          done_cnt = 0;
  int          both_cnt = 0;
  int          outs = 0;
  int          max_outs = 0;
  logic        rsp_pending = 1'b0;
  logic [17:0] rsp_addr = '0;
  logic        stall_en = 1'b0;
  logic        have_plan = 1'b0;
  int          stall_left = 0;
  logic        hold_chk = 1'b0;
  logic [51:0] hold_snap = '0;

  shared_mem_copy_master dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_src           (cmd_src),
    .cmd_dst           (cmd_dst),
    .cmd_len           (cmd_len),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .dbg_state         (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    return {8'hC3, 6'h15, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // bus monitor: records accepted transfers, counts done pulses and outstanding reads
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) begin
      rsp_pending = 1'b1;
      rsp_addr = avm_address;
      rd_log.push_back(avm_address);
    end
    outs = outs + ((avm_read && !avm_waitrequest) ? 1 : 0) - (avm_readdatavalid ? 1 : 0);
    if (outs > max_outs) max_outs = outs;
    if (avm_write && !avm_waitrequest) begin
      wr_a.push_back(avm_address);
      wr_d.push_back(avm_writedata);
    end
    if (done) done_cnt++;
    if (avm_read && avm_write) both_cnt++;
  end

  // memory responder: read data one cycle after acceptance, optional stalls of 0-3 cycles
  always @(negedge clk) begin
    if (hold_chk)
      check("stall_hold", {avm_read, avm_write, avm_address, avm_writedata}, hold_snap);
    avm_readdatavalid = rsp_pending;
    avm_readdata = rsp_pending ? mem_word(rsp_addr) : 32'h0;
    rsp_pending = 1'b0;
    if (stall_en && (avm_read || avm_write)) begin
      if (!have_plan) begin
        stall_left = $urandom_range(0, 3);
        have_plan = 1'b1;
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        have_plan = 1'b0;
      end
    end else begin
      avm_waitrequest = 1'b0;
      have_plan = 1'b0;
    end
    hold_chk = (avm_read || avm_write) && avm_waitrequest;
    hold_snap = {avm_read, avm_write, avm_address, avm_writedata};
  end

  task automatic run_copy(input logic [17:0] src, input logic [17:0] dst, input logic [15:0] len,
                          output int cyc);
    logic seen;
    @(negedge clk);
    rd_log.delete(); wr_a.delete(); wr_d.delete();
    done_cnt = 0; both_cnt = 0;
    cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst; cmd_len = len;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("ready_after_done", 64'(cmd_ready), 64'd1);
    check("done_count", 64'(done_cnt), 64'd1);
    check("never_both_strobes", 64'(both_cnt), 64'd0);
  endtask

  task automatic check_copy(input logic [17:0] src, input logic [17:0] dst, input int len);
    logic [17:0] ra;
    logic [17:0] wa;
    check("read_count", 64'(rd_log.size()), 64'(len));
    check("write_count", 64'(wr_a.size()), 64'(len));
    for (int i = 0; i < len; i++) begin
      ra = (src & 18'h3FFFC) + 18'(4 * i);
      wa = (dst & 18'h3FFFC) + 18'(4 * i);
      if (i < rd_log.size()) check("read_addr", 64'(rd_log[i]), 64'(ra));
      if (i < wr_a.size()) begin
        check("write_addr", 64'(wr_a[i]), 64'(wa));
        check("write_data", 64'(wr_d[i]), 64'(mem_word(ra)));
      end
    end
  endtask

  initial begin
    int cyc;
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_strobes", 64'({avm_read, avm_write}), 64'd0);
    check("rst_address", 64'(avm_address), 64'd0);
    check("rst_writedata", 64'(avm_writedata), 64'd0);
    check("byteenable", 64'(avm_byteenable), 64'hF);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single word: minimum latency
    run_copy(18'h00040, 18'h00080, 16'd1, cyc);
    check("latency_1word_le5", 64'(cyc <= 5), 64'd1);
    check_copy(18'h00040, 18'h00080, 1);

    // four words, zero wait
    run_copy(18'h00100, 18'h02000, 16'd4, cyc);
    check_copy(18'h00100, 18'h02000, 4);

    // zero length: no bus traffic, immediate done
    run_copy(18'h00300, 18'h00400, 16'd0, cyc);
    check("len0_latency_le2", 64'(cyc <= 2), 64'd1);
    check_copy(18'h00300, 18'h00400, 0);

    // eight words with random stalls
    max_outs = 0;
    stall_en = 1'b1;
    run_copy(18'h00400, 18'h00800, 16'd8, cyc);
    stall_en = 1'b0;
    check_copy(18'h00400, 18'h00800, 8);
    check("max_outstanding_le4", 64'(max_outs <= 4), 64'd1);

    // source address wraps at the top of memory
    run_copy(18'h3FFF8, 18'h01000, 16'd4, cyc);
    check_copy(18'h3FFF8, 18'h01000, 4);
    check("wrap_read2", 64'(rd_log.size() > 2 ? rd_log[2] : 18'h3FFFF), 64'h00000);

    // misaligned addresses are forced to word boundaries
    run_copy(18'h00103, 18'h00203, 16'd1, cyc);
    check("misaligned_read", 64'(rd_log.size() > 0 ? rd_log[0] : 18'h3FFFF), 64'h00100);
    check_copy(18'h00103, 18'h00203, 1);

    // reset after three of eight writes
    @(negedge clk);
    rd_log.delete(); wr_a.delete(); wr_d.delete();
    done_cnt = 0;
    cmd_valid = 1'b1; cmd_src = 18'h00500; cmd_dst = 18'h00600; cmd_len = 16'd8;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    while (wr_a.size() < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_3_writes", 64'(wr_a.size()), 64'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_strobes_low", 64'({avm_read, avm_write}), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    run_copy(18'h00700, 18'h00900, 16'd2, cyc);
    check_copy(18'h00700, 18'h00900, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
